timestamp_merge_arbiter: RTL and testbench

- Merges N decoupled timestamped streams into one globally time-ordered stream. Each input stream carries (data, time) pairs, one stream per reference timestamper.
- Sits between the per-signal timestampers and the single token-stream comparator, which is shared by all sources.
- Releases a record only when every live source has presented its head. This guarantees that no earlier record can still arrive.
- Tags each output with its source index and flags any time regression.

---
 rtl/timestamp_merge_pkg.sv | 29 ++
 rtl/timestamp_min_select.sv | 51 +++++
 rtl/timestamp_merge_arbiter.sv | 152 +++++++++++++++
 tb/tb_timestamp_merge_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_merge_pkg.sv
// Shared types and helpers for the timestamp merge arbiter and its min-select tree.
package timestamp_merge_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_TIME_WIDTH = 64;

  // One timestamped record at the default widths; the field is named ts
  // because time is a reserved word.
  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH-1:0] data;
    logic [DEFAULT_TIME_WIDTH-1:0] ts;
  } ts_record_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } merge_state_e;

  // Tie-break rule for one tree node: returns 1 when the right (higher-index)
  // candidate wins. The right side only wins on a strictly smaller time, so
  // equal times resolve to the lowest index.
  function automatic logic min_index(input logic left_valid,
                                     input logic right_valid,
                                     input logic right_less);
    return right_valid && (!left_valid || right_less);
  endfunction

endpackage

// File: rtl/timestamp_min_select.sv
// Combinational argmin over N valid-masked unsigned timestamps, built as a
// balanced binary tree (heap layout, leaves padded to a power of two).
module timestamp_min_select
  import timestamp_merge_pkg::*;
#(
  parameter int N          = 4,
  parameter int TIME_WIDTH = 64,
  parameter int IDX_W      = $clog2(N)
) (
  input  logic [N-1:0]            valid,
  input  logic [N*TIME_WIDTH-1:0] times,
  output logic [IDX_W-1:0]        min_idx,
  output logic                    found
);

  localparam int LEAVES = 1 << $clog2(N);
  localparam int NODES  = 2 * LEAVES - 1;

  logic                  node_v [NODES];
  logic [TIME_WIDTH-1:0] node_t [NODES];
  logic [IDX_W-1:0]      node_i [NODES];

  // Fill the leaves, then reduce pairwise toward the root; left subtrees hold
  // lower indices so a tie keeps the left child.
  always_comb begin
    for (int k = 0; k < NODES; k++) begin
      node_v[k] = 1'b0;
      node_t[k] = '0;
      node_i[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      node_v[LEAVES-1+i] = valid[i];
      node_t[LEAVES-1+i] = times[i*TIME_WIDTH +: TIME_WIDTH];
      node_i[LEAVES-1+i] = IDX_W'(i);
    end
    for (int k = LEAVES - 2; k >= 0; k--) begin
      if (min_index(node_v[2*k+1], node_v[2*k+2], node_t[2*k+2] < node_t[2*k+1])) begin
        node_v[k] = node_v[2*k+2];
        node_t[k] = node_t[2*k+2];
        node_i[k] = node_i[2*k+2];
      end else begin
        node_v[k] = node_v[2*k+1];
        node_t[k] = node_t[2*k+1];
        node_i[k] = node_i[2*k+1];
      end
    end
    min_idx = node_i[0];
    found   = node_v[0];
  end

endmodule

// File: rtl/timestamp_merge_arbiter.sv
// Merges N timestamped streams into one time-ordered stream. A record is only
// released once every live source shows its head, so nothing earlier can
// still arrive. Output is a single register stage tagged with its source.
module timestamp_merge_arbiter
  import timestamp_merge_pkg::*;
#(
  parameter int N_SOURCES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIME_WIDTH = 64,
  localparam int SRC_W     = $clog2(N_SOURCES)
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_SOURCES-1:0]             in_valid,
  output logic [N_SOURCES-1:0]             in_ready,
  input  logic [N_SOURCES*DATA_WIDTH-1:0]  in_bits_data,
  input  logic [N_SOURCES*TIME_WIDTH-1:0]  in_bits_time,
  input  logic [N_SOURCES-1:0]             src_done,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_bits_data,
  output logic [TIME_WIDTH-1:0]            out_bits_time,
  output logic [SRC_W-1:0]                 out_bits_source,
  output logic                             all_done,
  output logic                             order_error
);

  merge_state_e            state_q, state_d;
  logic [N_SOURCES-1:0]    done_q, done_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [TIME_WIDTH-1:0]   out_time_q, out_time_d;
  logic [SRC_W-1:0]        out_src_q, out_src_d;
  logic [TIME_WIDTH-1:0]   last_time_q, last_time_d;
  logic                    order_error_q, order_error_d;

  logic [SRC_W-1:0]        sel_idx_s;
  logic                    sel_found_s;
  logic                    eligible_s;
  logic                    load_s;
  logic                    fire_s;
  logic [N_SOURCES-1:0]    in_ready_s;

  timestamp_min_select #(
    .N          (N_SOURCES),
    .TIME_WIDTH (TIME_WIDTH),
    .IDX_W      (SRC_W)
  ) u_min_select (
    .valid   (in_valid),
    .times   (in_bits_time),
    .min_idx (sel_idx_s),
    .found   (sel_found_s)
  );

  // Decide whether a record can move this cycle: every source must be either
  // showing a head or finished, and the output slot must be free or emptying.
  always_comb begin
    eligible_s = (&(in_valid | done_q)) && sel_found_s;
    fire_s     = out_valid_q && out_ready;
    if (state_q != DONE) begin
      load_s = eligible_s && (!out_valid_q || out_ready);
    end else begin
      load_s = 1'b0;
    end
  end

  // One-hot pop of the winning source in the load cycle; held low in reset.
  always_comb begin
    in_ready_s = '0;
    if (load_s && !reset) begin
      in_ready_s[sel_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Next-state for the output register, order checker, done flags and FSM.
  always_comb begin
    done_d        = done_q | src_done;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_time_d    = out_time_q;
    out_src_d     = out_src_q;
    last_time_d   = last_time_q;
    order_error_d = order_error_q;
    state_d       = state_q;

    if (load_s) begin
      out_valid_d = 1'b1;
      out_data_d  = in_bits_data[int'(sel_idx_s)*DATA_WIDTH +: DATA_WIDTH];
      out_time_d  = in_bits_time[int'(sel_idx_s)*TIME_WIDTH +: TIME_WIDTH];
      out_src_d   = sel_idx_s;
    end else if (fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (fire_s) begin
      order_error_d = order_error_q | (out_time_q < last_time_q);
      last_time_d   = out_time_q;
    end else begin
      order_error_d = order_error_q;
      last_time_d   = last_time_q;
    end

    case (state_q)
      RUN: begin
        if (&done_q) state_d = DRAIN;
        else         state_d = RUN;
      end
      DRAIN: begin
        if (!(|in_valid) && !out_valid_q) state_d = DONE;
        else                              state_d = DRAIN;
      end
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  // State registers; async reset drops any in-flight output without handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RUN;
      done_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_time_q    <= '0;
      out_src_q     <= '0;
      last_time_q   <= '0;
      order_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      done_q        <= done_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_time_q    <= out_time_d;
      out_src_q     <= out_src_d;
      last_time_q   <= last_time_d;
      order_error_q <= order_error_d;
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = out_valid_q;
  assign out_bits_data   = out_data_q;
  assign out_bits_time   = out_time_q;
  assign out_bits_source = out_src_q;
  assign order_error     = order_error_q;
  assign all_done        = (state_q == DONE);

endmodule

// File: tb/tb_timestamp_merge_arbiter.sv
// Directed bench for the merge arbiter with two sources; each source is a
// bench-side queue popped whenever in_ready was high at a clock edge.
module tb_timestamp_merge_arbiter;
  import timestamp_merge_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    in_valid;
  logic [1:0]    in_ready;
  logic [15:0]   in_bits_data;
  logic [127:0]  in_bits_time;
  logic [1:0]    src_done;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_bits_data;
  logic [63:0]   out_bits_time;
  logic          out_bits_source;
  logic          all_done;
  logic          order_error;

  int tests = 0;
  int fails = 0;

  ts_record_t q0[$];
  ts_record_t q1[$];

  timestamp_merge_arbiter #(
    .N_SOURCES  (2),
    .DATA_WIDTH (8),
    .TIME_WIDTH (64)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_bits_data    (in_bits_data),
    .in_bits_time    (in_bits_time),
    .src_done        (src_done),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_bits_data   (out_bits_data),
    .out_bits_time   (out_bits_time),
    .out_bits_source (out_bits_source),
    .all_done        (all_done),
    .order_error     (order_error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic [63:0] t, input logic s);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_bits_data), 64'(d));
    chk({tag, "_time"}, out_bits_time, t);
    chk({tag, "_src"}, 64'(out_bits_source), 64'(s));
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic [63:0] t);
    ts_record_t r;
    r.data = d;
    r.ts   = t;
    if (s == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Present queue heads on the source ports, then let logic settle.
  task automatic drive();
    in_valid[0]          = (q0.size() > 0);
    in_bits_data[7:0]    = (q0.size() > 0) ? q0[0].data : 8'h00;
    in_bits_time[63:0]   = (q0.size() > 0) ? q0[0].ts : 64'd0;
    in_valid[1]          = (q1.size() > 0);
    in_bits_data[15:8]   = (q1.size() > 0) ? q1[0].data : 8'h00;
    in_bits_time[127:64] = (q1.size() > 0) ? q1[0].ts : 64'd0;
    #1;
  endtask

  // Advance one clock: pop every source that was handshaked at the edge.
  task automatic tick();
    logic [1:0] rdy;
    rdy = in_ready;
    @(posedge clock);
    #1;
    if (rdy[0] && in_valid[0]) void'(q0.pop_front());
    if (rdy[1] && in_valid[1]) void'(q1.pop_front());
    src_done = 2'b00;
    drive();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    src_done  = 2'b00;
    out_ready = 1'b0;
    drive();
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
  endtask

  logic [7:0]  exp_d [4];
  logic [63:0] exp_t [4];
  logic        exp_s [4];

  initial begin
    reset        = 1'b1;
    in_valid     = 2'b00;
    in_bits_data = '0;
    in_bits_time = '0;
    src_done     = 2'b00;
    out_ready    = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);
    chk("rst_order_error", 64'(order_error), 64'd0);
    chk("rst_out_time", out_bits_time, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive();

    // Smaller time wins regardless of source index.
    push(0, 8'h0A, 64'd100);
    push(1, 8'h0B, 64'd50);
    out_ready = 1'b1;
    drive();
    chk("t1_ready_first", 64'(in_ready), 64'd2);
    tick();
    chk_out("t1_rec0", 8'h0B, 64'd50, 1'b1);
    chk("t1_stall_ready", 64'(in_ready), 64'd0);
    src_done = 2'b10;
    tick();
    chk("t1_gap_valid", 64'(out_valid), 64'd0);
    chk("t1_ready_src0", 64'(in_ready), 64'd1);
    tick();
    chk_out("t1_rec1", 8'h0A, 64'd100, 1'b0);
    chk("t1_order", 64'(order_error), 64'd0);

    // A live source without a head stalls the merge.
    do_reset();
    push(0, 8'h11, 64'd10);
    out_ready = 1'b1;
    drive();
    for (int c = 0; c < 20; c++) begin
      chk("t2_stall", 64'({out_valid, in_ready}), 64'd0);
      tick();
    end
    push(1, 8'h22, 64'd5);
    drive();
    chk("t2_ready", 64'(in_ready), 64'd2);
    tick();
    chk_out("t2_rec0", 8'h22, 64'd5, 1'b1);

    // Equal times go to the lower index first.
    do_reset();
    push(0, 8'h33, 64'd77);
    push(1, 8'h44, 64'd77);
    out_ready = 1'b1;
    drive();
    chk("t3_ready_tie", 64'(in_ready), 64'd1);
    tick();
    chk_out("t3_rec0", 8'h33, 64'd77, 1'b0);
    src_done = 2'b01;
    tick();
    chk("t3_ready_src1", 64'(in_ready), 64'd2);
    tick();
    chk_out("t3_rec1", 8'h44, 64'd77, 1'b1);
    chk("t3_order", 64'(order_error), 64'd0);

    // Backpressure holds the output; release streams one record per cycle.
    do_reset();
    push(0, 8'h01, 64'd10);
    push(0, 8'h02, 64'd20);
    push(0, 8'h03, 64'd30);
    push(1, 8'h04, 64'd15);
    push(1, 8'h05, 64'd25);
    src_done  = 2'b10;
    out_ready = 1'b0;
    drive();
    chk("t4_ready_first", 64'(in_ready), 64'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk_out("t4_hold", 8'h01, 64'd10, 1'b0);
      chk("t4_hold_ready", 64'(in_ready), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    drive();
    chk("t4_release_ready", 64'(in_ready), 64'd2);
    exp_d[0] = 8'h04; exp_t[0] = 64'd15; exp_s[0] = 1'b1;
    exp_d[1] = 8'h02; exp_t[1] = 64'd20; exp_s[1] = 1'b0;
    exp_d[2] = 8'h05; exp_t[2] = 64'd25; exp_s[2] = 1'b1;
    exp_d[3] = 8'h03; exp_t[3] = 64'd30; exp_s[3] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk_out("t4_stream", exp_d[j], exp_t[j], exp_s[j]);
    end
    tick();
    chk("t4_empty", 64'(out_valid), 64'd0);
    chk("t4_order", 64'(order_error), 64'd0);

    // All sources done with nothing queued reaches DONE and stays idle.
    do_reset();
    src_done = 2'b11;
    drive();
    tick();
    tick();
    tick();
    chk("t5_all_done", 64'(all_done), 64'd1);
    push(0, 8'h09, 64'd9);
    drive();
    chk("t5_done_ready", 64'(in_ready), 64'd0);
    tick();
    chk("t5_done_valid", 64'(out_valid), 64'd0);
    chk("t5_done_hold", 64'(all_done), 64'd1);

    // One source finished while the other streams without stalls.
    do_reset();
    push(0, 8'h01, 64'd1);
    push(0, 8'h02, 64'd2);
    push(0, 8'h03, 64'd3);
    src_done  = 2'b10;
    out_ready = 1'b1;
    drive();
    chk("t5b_wait_done", 64'(in_ready), 64'd0);
    tick();
    chk("t5b_ready", 64'(in_ready), 64'd1);
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk_out("t5b_stream", 8'(j), 64'(j), 1'b0);
    end

    // Time regression sets a sticky error; async reset clears everything.
    do_reset();
    push(0, 8'h60, 64'd60);
    src_done  = 2'b10;
    out_ready = 1'b1;
    drive();
    tick();
    tick();
    chk_out("t6_rec60", 8'h60, 64'd60, 1'b0);
    push(0, 8'h40, 64'd40);
    drive();
    tick();
    chk_out("t6_rec40", 8'h40, 64'd40, 1'b0);
    chk("t6_no_err_yet", 64'(order_error), 64'd0);
    tick();
    chk("t6_err_set", 64'(order_error), 64'd1);
    push(0, 8'h70, 64'd70);
    out_ready = 1'b0;
    drive();
    tick();
    chk("t6_err_sticky", 64'(order_error), 64'd1);
    chk_out("t6_rec70", 8'h70, 64'd70, 1'b0);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_data", 64'(out_bits_data), 64'd0);
    chk("t6_rst_time", out_bits_time, 64'd0);
    chk("t6_rst_err", 64'(order_error), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
